// File: rtl/mux_pipe.sv
`default_nettype none
// ============================================================================
// mux_pipe : NUM_IN-to-1 channel mux feeding a 2-entry skid buffer (valid/ready)
//            Optional macro MUX_SEL_ERR_EN adds the sel_err flag.  Rev 1.0
// ============================================================================
module mux_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef MUX_SEL_ERR_EN
  output logic                    sel_err,
`endif
  output logic [WIDTH-1:0]        data_out
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_accept;
  logic             w_consume;
  logic             w_load_main_in;
  logic             w_load_main_skid;
  logic             w_load_skid;

  // Out-of-range selects match no channel and therefore yield zero.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) w_sel_data = data_in[k*WIDTH +: WIDTH];
    end
  end

  assign w_accept  = in_valid && r_in_ready;
  assign w_consume = r_out_valid && out_ready;

  always_comb begin
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_next   = ONE;
          w_load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_consume) begin
          w_load_main_in = 1'b1;
        end else if (w_accept) begin
          w_state_next = FULL;
          w_load_skid  = 1'b1;
        end else if (w_consume) begin
          w_state_next = EMPTY;
        end
      end
      FULL: begin
        if (w_consume) begin
          w_state_next     = ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_next = EMPTY;
    endcase
  end

  // Handshake flags are registered from the next state so in_ready has no input path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next != FULL);
      r_out_valid <= (w_state_next != EMPTY);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in)        r_main <= w_sel_data;
      else if (w_load_main_skid) r_main <= r_skid;
      if (w_load_skid)           r_skid <= w_sel_data;
    end
  end

`ifdef MUX_SEL_ERR_EN
  logic r_main_err;
  logic r_skid_err;
  logic w_sel_err;

  assign w_sel_err = (int'(sel) >= NUM_IN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_err <= 1'b0;
      r_skid_err <= 1'b0;
    end else begin
      if (w_load_main_in)        r_main_err <= w_sel_err;
      else if (w_load_main_skid) r_main_err <= r_skid_err;
      if (w_load_skid)           r_skid_err <= w_sel_err;
    end
  end

  assign sel_err = r_main_err;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign data_out  = r_main;

endmodule
`default_nettype wire
